// File: rtl/serial_add_seq.sv
// serial_add_seq: digit-serial adder sequencer.
// Adds two WIDTH-bit operands using a single 2-bit digit slice, one digit
// per clock, LSB digit first. The carry between digits is held in a register.
// Handshake: start is accepted in IDLE or DONE. busy is high while digits
// are processed. done pulses for one cycle when sum/cout are valid.
// WIDTH must be even and at least 4.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N     = WIDTH / 2;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [IDX_W-1:0] idx;

    logic [1:0]       dig_a;
    logic [1:0]       dig_b;
    logic [1:0]       dig_sum;
    logic             dig_carry;

    // Carry out of a 2-bit digit add, in carry-lookahead form.
    function automatic logic carry2(input logic a1, input logic a0,
                                    input logic b1, input logic b0,
                                    input logic ci);
        carry2 = (a1 & b1)
               | (a1 & a0 & b0)
               | (a0 & b1 & b0)
               | (ci & (a1 | b1) & (a0 | b0 | (a1 & b1)));
    endfunction

    // Low two bits of a 2-bit digit add; the carry comes from carry2.
    function automatic logic [1:0] digit_sum2(input logic [1:0] x,
                                              input logic [1:0] y,
                                              input logic       ci);
        digit_sum2 = x + y + {1'b0, ci};
    endfunction

    // Select the operand digit addressed by idx and evaluate the digit slice.
    always_comb begin
        dig_a = '0;
        dig_b = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IDX_W'(i)) begin
                dig_a = a_q[2*i +: 2];
                dig_b = b_q[2*i +: 2];
            end
        end
        dig_sum   = digit_sum2(dig_a, dig_b, carry);
        dig_carry = carry2(dig_a[1], dig_a[0], dig_b[1], dig_b[0], carry);
    end

    // Sequencer FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            idx   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= cin;
                        idx   <= '0;
                        sum   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    for (int i = 0; i < N; i++) begin
                        if (idx == IDX_W'(i)) begin
                            sum[2*i +: 2] <= dig_sum;
                        end
                    end
                    carry <= dig_carry;
                    if (idx == IDX_LAST) begin
                        // Last digit: publish the carry and park idx at zero.
                        cout  <= dig_carry;
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// Testbench for serial_add_seq (WIDTH=8, N=4).
// Results are compared against plain integer addition; done timing is
// compared against the N+1 cycle latency of the handshake.
module tb_serial_add_seq;

    localparam int WIDTH = 8;
    localparam int N     = WIDTH / 2;
    localparam int LAT   = N + 1;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int checks;
    int failures;

    serial_add_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until done is seen, starting from cycle index n0 after the
    // accepting edge. Reports the cycle index of done and busy cycles seen.
    task automatic wait_done(input int n0, output int lat, output int nbusy);
        int n;
        n = n0;
        nbusy = 0;
        while (!done && n < n0 + 30) begin
            if (busy) nbusy++;
            tick();
            n++;
        end
        lat = n;
    endtask

    // Issue one add and wait for its done; inputs are scrambled after accept.
    task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                          input logic ic, output int lat, output int nbusy);
        a = ia; b = ib; cin = ic; start = 1'b1;
        tick();
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
        wait_done(1, lat, nbusy);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (sum !== 8'h00) begin failures++; $display("FAIL reset_sum got=%h exp=00", sum); end
        checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
        reset = 1'b0; start = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_start_dropped got=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        int lat, nb;
        run_op(8'h0F, 8'h01, 1'b0, lat, nb);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (nb !== N) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", nb, N); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
        checks++; if (sum !== 8'h10) begin failures++; $display("FAIL basic_sum got=%h exp=10", sum); end
        checks++; if (cout !== 1'b0) begin failures++; $display("FAIL basic_cout got=%b exp=0", cout); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_width got=%b exp=0", done); end
        checks++; if (sum !== 8'h10) begin failures++; $display("FAIL basic_sum_held got=%h exp=10", sum); end
    endtask

    task automatic test_carry();
        int lat, nb;
        run_op(8'hFF, 8'h01, 1'b0, lat, nb);
        checks++; if ({cout, sum} !== 9'h100) begin failures++; $display("FAIL carry_ff01 got=%h exp=100", {cout, sum}); end
        tick();
        run_op(8'hFF, 8'hFF, 1'b1, lat, nb);
        checks++; if ({cout, sum} !== 9'h1FF) begin failures++; $display("FAIL carry_ffff1 got=%h exp=1ff", {cout, sum}); end
        checks++; if (lat !== LAT) begin failures++; $display("FAIL carry_latency got=%0d exp=%0d", lat, LAT); end
    endtask

    task automatic test_back_to_back();
        int lat, nb;
        tick();
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        tick();                                   // cycle 1
        start = 1'b0;
        tick();                                   // cycle 2
        a = 8'h55; b = 8'h55; cin = 1'b1; start = 1'b1;
        tick();                                   // cycle 3
        start = 1'b0;
        wait_done(3, lat, nb);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if ({cout, sum} !== 9'h010) begin failures++; $display("FAIL ignore_result got=%h exp=010", {cout, sum}); end
        // Start in the DONE cycle.
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", busy); end
        wait_done(1, lat, nb);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if ({cout, sum} !== 9'h003) begin failures++; $display("FAIL b2b_result got=%h exp=003", {cout, sum}); end
    endtask

    task automatic test_reset_mid();
        int ndone;
        tick();
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        tick();                                   // cycle 1
        start = 1'b0;
        tick();                                   // cycle 2
        tick();                                   // cycle 3
        reset = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL midreset_done got=%b exp=0", done); end
        checks++; if (sum !== 8'h00) begin failures++; $display("FAIL midreset_sum got=%h exp=00", sum); end
        checks++; if (cout !== 1'b0) begin failures++; $display("FAIL midreset_cout got=%b exp=0", cout); end
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) ndone++;
        end
        checks++; if (ndone !== 0) begin failures++; $display("FAIL midreset_no_done got=%0d exp=0", ndone); end
    endtask

    task automatic test_random();
        int lat, nb, gap;
        logic [WIDTH-1:0] ra, rb;
        logic             rc;
        logic [WIDTH:0]   exp;
        tick();
        for (int k = 0; k < 1000; k++) begin
            ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
            exp = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
            run_op(ra, rb, rc, lat, nb);
            checks++; if (lat !== LAT) begin failures++; $display("FAIL rand_latency op=%0d got=%0d exp=%0d", k, lat, LAT); end
            checks++; if (nb !== N) begin failures++; $display("FAIL rand_busy op=%0d got=%0d exp=%0d", k, nb, N); end
            checks++; if ({cout, sum} !== exp) begin failures++; $display("FAIL rand_result op=%0d a=%h b=%h cin=%b got=%h exp=%h", k, ra, rb, rc, {cout, sum}, exp); end
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                tick();
                checks++; if (done !== 1'b0) begin failures++; $display("FAIL rand_done_width op=%0d got=%b exp=0", k, done); end
                checks++; if ({cout, sum} !== exp) begin failures++; $display("FAIL rand_hold op=%0d got=%h exp=%h", k, {cout, sum}, exp); end
                if (gap > 1) tick();
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
